// File: rtl/spi_pkg.sv
// Shared SPI receive constants: bit-order and parity-sense encodings plus
// the bit-counter width helper.
package spi_pkg;

  localparam logic SPI_LSB_FIRST = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  localparam int unsigned SPI_PARITY_EVEN = 0;
  localparam int unsigned SPI_PARITY_ODD  = 1;

  // Counter width able to hold 0..nbits-1.
  function automatic int unsigned spi_cnt_w(input int unsigned nbits);
    return (nbits < 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: assembles DATA_W-bit words from per-bit sample strobes.
// Optional trailing parity check is enabled by defining SPI_RX_PARITY_EN.
module spi_rx_deser #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              im_work_en,
  input  logic              im_work_pluse,
  input  logic              im_data,
  input  logic              im_msb_first,
  output logic [DATA_W-1:0] om_data,
  output logic              om_valid,
  output logic              om_busy,
  output logic              om_abort
`ifdef SPI_RX_PARITY_EN
  ,
  output logic              om_parity_err
`endif
);
  import spi_pkg::*;

`ifdef SPI_RX_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif
  localparam int unsigned CW = spi_cnt_w(NBITS);

  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
    $error("spi_rx_deser: DATA_W must be in 2..32");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("spi_rx_deser: PARITY_ODD must be 0 or 1");
  end

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic              ord_q;
  logic              ord_cur;
  logic              accept;

  // The first bit of a word takes its order straight from the input.
  always_comb begin
    ord_cur = (cnt == '0) ? im_msb_first : ord_q;
    sh_nxt  = (ord_cur == SPI_MSB_FIRST) ? {sh[DATA_W-2:0], im_data}
                                         : {im_data, sh[DATA_W-1:1]};
    accept  = im_work_en & im_work_pluse;
  end

  assign om_busy = (cnt != '0);

`ifdef SPI_RX_PARITY_EN
  logic par_q;

  // Data bits shift in; the bit after the last data bit is parity only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      sh            <= '0;
      ord_q         <= 1'b0;
      par_q         <= 1'b0;
      om_data       <= '0;
      om_valid      <= 1'b0;
      om_abort      <= 1'b0;
      om_parity_err <= 1'b0;
    end else begin
      om_valid <= 1'b0;
      om_abort <= 1'b0;
      if (!im_work_en) begin
        cnt      <= '0;
        om_abort <= (cnt != '0);
      end else if (accept) begin
        if (cnt == '0) ord_q <= im_msb_first;
        if (cnt == CW'(DATA_W)) begin
          om_data       <= sh;
          om_valid      <= 1'b1;
          om_parity_err <= (par_q ^ im_data) != 1'(PARITY_ODD);
          cnt           <= '0;
        end else begin
          sh    <= sh_nxt;
          par_q <= (cnt == '0) ? im_data : (par_q ^ im_data);
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end
`else
  // Last data bit publishes the shifted value including the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sh       <= '0;
      ord_q    <= 1'b0;
      om_data  <= '0;
      om_valid <= 1'b0;
      om_abort <= 1'b0;
    end else begin
      om_valid <= 1'b0;
      om_abort <= 1'b0;
      if (!im_work_en) begin
        cnt      <= '0;
        om_abort <= (cnt != '0);
      end else if (accept) begin
        if (cnt == '0) ord_q <= im_msb_first;
        sh <= sh_nxt;
        if (cnt == CW'(DATA_W - 1)) begin
          om_data  <= sh_nxt;
          om_valid <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// Bench for spi_rx_deser: 8-bit and 16-bit instances share one input stream and
// are checked every cycle against a bit-list model; honours SPI_RX_PARITY_EN.
module tb_spi_rx_deser;

`ifdef SPI_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PODD = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, pl, d, msb;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic v8, b8, a8, v16, b16, a16;
  logic p8, p16;

  spi_rx_deser #(.DATA_W(8), .PARITY_ODD(PODD)) u8 (
    .clk(clk), .rst_n(rst_n), .im_work_en(en), .im_work_pluse(pl),
    .im_data(d), .im_msb_first(msb), .om_data(d8), .om_valid(v8),
    .om_busy(b8), .om_abort(a8)
`ifdef SPI_RX_PARITY_EN
    , .om_parity_err(p8)
`endif
  );

  spi_rx_deser #(.DATA_W(16), .PARITY_ODD(PODD)) u16 (
    .clk(clk), .rst_n(rst_n), .im_work_en(en), .im_work_pluse(pl),
    .im_data(d), .im_msb_first(msb), .om_data(d16), .om_valid(v16),
    .om_busy(b16), .om_abort(a16)
`ifdef SPI_RX_PARITY_EN
    , .om_parity_err(p16)
`endif
  );

`ifndef SPI_RX_PARITY_EN
  assign p8  = 1'b0;
  assign p16 = 1'b0;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int v16_hist[$];

  // Model: received bits of the current word per instance (0 = 8-bit, 1 = 16-bit).
  int          cnt_m[2];
  bit          bits_m[2][33];
  bit          ord_m[2];
  logic [31:0] ed[2];
  bit          ev[2], ea[2], ep[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = 0; ord_m[i] = 0; ed[i] = '0;
      ev[i] = 0; ea[i] = 0; ep[i] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit p, input bit dd, input bit m);
    for (int i = 0; i < 2; i++) begin
      int w, nb;
      logic [31:0] wd;
      bit par;
      w  = (i == 0) ? 8 : 16;
      nb = w + PAR;
      ev[i] = 0;
      ea[i] = 0;
      if (!e) begin
        ea[i]    = (cnt_m[i] != 0);
        cnt_m[i] = 0;
      end else if (p) begin
        if (cnt_m[i] == 0) ord_m[i] = m;
        bits_m[i][cnt_m[i]] = dd;
        cnt_m[i]++;
        if (cnt_m[i] == nb) begin
          wd = '0;
          for (int j = 0; j < w; j++) begin
            if (ord_m[i]) wd[w-1-j] = bits_m[i][j];
            else          wd[j]     = bits_m[i][j];
          end
          par = 0;
          for (int j = 0; j < nb; j++) par ^= bits_m[i][j];
          ed[i]    = wd;
          ev[i]    = 1;
          ep[i]    = (par != PODD[0]);
          cnt_m[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("data8",  32'(d8),  32'(ed[0][7:0]));
    check("valid8", 32'(v8),  32'(ev[0]));
    check("busy8",  32'(b8),  32'(cnt_m[0] != 0));
    check("abort8", 32'(a8),  32'(ea[0]));
    check("data16",  32'(d16), 32'(ed[1][15:0]));
    check("valid16", 32'(v16), 32'(ev[1]));
    check("busy16",  32'(b16), 32'(cnt_m[1] != 0));
    check("abort16", 32'(a16), 32'(ea[1]));
    if (PAR != 0) begin
      check("perr8",  32'(p8),  32'(ep[0]));
      check("perr16", 32'(p16), 32'(ep[1]));
    end
  endtask

  task automatic step(input bit e, input bit p, input bit dd, input bit m);
    en = e; pl = p; d = dd; msb = m;
    model_step(e, p, dd, m);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
    if (v16) v16_hist.push_back(cyc);
  endtask

  task automatic send_word8(input logic [7:0] v, input bit m, input bit pb);
    for (int j = 0; j < 8; j++) step(1, 1, m ? v[7-j] : v[j], m);
    if (PAR != 0) step(1, 1, pb, m);
  endtask

  task automatic send_word16(input logic [15:0] v, input bit m, input bit pb);
    for (int j = 0; j < 16; j++) step(1, 1, m ? v[15-j] : v[j], m);
    if (PAR != 0) step(1, 1, pb, m);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; pl = 0; d = 0; msb = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // LSB-first 0xA5, valid for exactly one cycle
    send_word8(8'hA5, 0, 0);
    check("lit_lsb_a5_valid", 32'(v8), 32'h1);
    check("lit_lsb_a5_data", 32'(d8), 32'hA5);
    step(1, 0, 0, 0);
    check("lit_valid_one_cycle", 32'(v8), 32'h0);

    // MSB-first 0xA5 then LSB-first 0x1E
    step(0, 0, 0, 0);
    send_word8(8'hA5, 1, 0);
    check("lit_msb_a5_data", 32'(d8), 32'hA5);
    send_word8(8'h1E, 0, 0);
    check("lit_lsb_1e_data", 32'(d8), 32'h1E);

    // Abort after 3 bits; a pulse with enable low changes nothing
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("lit_busy_partial", 32'(b8), 32'h1);
    step(0, 1, 1, 0);
    check("lit_abort_pulse", 32'(a8), 32'h1);
    check("lit_abort_busy_low", 32'(b8), 32'h0);
    check("lit_abort_data_held", 32'(d8), 32'h1E);
    step(0, 1, 0, 0);
    check("lit_abort_once", 32'(a8), 32'h0);
    send_word8(8'h3C, 0, 0);
    check("lit_after_abort_3c", 32'(d8), 32'h3C);

    // Parity: 0xA5 has even weight
    if (PAR != 0) begin
      send_word8(8'hA5, 0, 0);
      check("lit_par_ok_valid", 32'(v8), 32'h1);
      check("lit_par_ok", 32'(p8), 32'h0);
      send_word8(8'hA5, 0, 1);
      check("lit_par_bad_valid", 32'(v8), 32'h1);
      check("lit_par_bad", 32'(p8), 32'h1);
    end

    // 16-bit back-to-back words
    step(0, 0, 0, 0);
    v16_hist.delete();
    send_word16(16'hBEEF, 1, 0);
    check("lit_beef", 32'(d16), 32'hBEEF);
    send_word16(16'h1234, 1, 0);
    check("lit_1234", 32'(d16), 32'h1234);
    check("lit_valid16_count", 32'(v16_hist.size()), 32'd2);
    if (v16_hist.size() == 2)
      check("lit_valid16_spacing", 32'(v16_hist[1] - v16_hist[0]), 32'(16 + PAR));

    // Reset mid-word clears everything without an abort
    step(0, 0, 0, 0);
    for (int j = 0; j < 5; j++) step(1, 1, 1, 1);
    #2 rst_n = 1'b0;
    en = 0; pl = 0;
    model_reset();
    #1;
    check("lit_rst_data8", 32'(d8), 32'h0);
    check("lit_rst_busy8", 32'(b8), 32'h0);
    check("lit_rst_abort8", 32'(a8), 32'h0);
    check("lit_rst_data16", 32'(d16), 32'h0);
    check("lit_rst_valid8", 32'(v8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    send_word8(8'h5A, 1, 0);
    check("lit_post_rst_5a", 32'(d8), 32'h5A);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      bit e, p;
      e = ($urandom_range(0, 19) != 0);
      p = ($urandom_range(0, 3) != 0);
      step(e, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

Parametrised SPI receive deserializer that follows the fixed 8-bit, LSB-first receiver. It collects serial bits on a per-bit sample pulse from the SPI bit-timing layer and assembles them into DATA_W-bit words. Bit order is selectable per word. It adds a registered word-valid strobe, a busy flag and abort reporting for partial words, and optionally checks a trailing parity bit. It sits between the SPI bit-timing layer and the byte/word consumer.

## Interface
- DATA_W, 8: word width in bits; legal range 2..32.
- PARITY_ODD, 0: parity sense; 0 = even, 1 = odd. Used only when SPI_RX_PARITY_EN is defined.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- im_work_en  in  1  frame enable; low = idle and clears any partial word.
- im_work_pluse  in  1  one-cycle sample strobe; im_data is valid in this cycle.
- im_data  in  1  serial data bit.
- im_msb_first  in  1  bit order; 1 = MSB first. Sampled only on the first bit of each word.
- om_data  out  DATA_W  last completed word; holds until the next word completes.
- om_valid  out  1  one-cycle pulse when om_data is updated.
- om_busy  out  1  high while a partial word is held (bit counter ≠ 0).
- om_abort  out  1  one-cycle pulse when im_work_en drops with a partial word held.
- om_parity_err  out  1  parity result of the last word; present only with SPI_RX_PARITY_EN.

## Operation
- Internal state:
  - shift register sh[DATA_W-1:0];
  - bit counter cnt, wide enough for 0..NBITS-1, where NBITS = DATA_W (+1 with parity);
  - order flag ord_q;
  - running parity accumulator (parity build only).
- Accepted bit: any cycle with im_work_en=1 and im_work_pluse=1.
- First bit of a word (cnt==0):
  - ord_q <= im_msb_first;
  - this cycle's shift uses im_msb_first directly, not ord_q.
- Shift rule:
  - MSB-first: sh <= {sh[DATA_W-2:0], im_data};
  - LSB-first: sh <= {im_data, sh[DATA_W-1:1]}.
  - After DATA_W bits, LSB-first therefore gives bit0 = first received bit.
- Last data bit, no parity (cnt==DATA_W-1):
  - om_data <= the shifted value including the current bit;
  - om_valid <= 1;
  - cnt <= 0.
- Parity build: the bit at cnt==DATA_W is the parity bit. It does not shift sh. On that bit:
  - om_data <= sh; om_valid <= 1; cnt <= 0;
  - om_parity_err <= (XOR of the DATA_W data bits ^ parity bit) != PARITY_ODD.
- im_work_en=0:
  - cnt <= 0; the pulse is ignored; sh is not modified; om_data is held;
  - om_abort <= (cnt != 0), which yields exactly one pulse per dropped partial word.
- Simultaneous im_work_en falling and im_work_pluse: enable wins, so the bit is discarded.
- om_busy = (cnt != 0), combinational from the register.
- Reset values: om_data=0, om_valid=0, om_abort=0, om_parity_err=0, om_busy=0, cnt=0, sh=0, ord_q=0.
- A reset mid-word discards the partial word without asserting om_abort.

## Timing
- Latency: om_valid is high in the cycle after the clock edge that samples the last bit (the data bit, or the parity bit in the parity build); om_data is valid in that same cycle.
- Back-to-back: pulses may arrive every cycle. Word N's om_valid coincides with the first bit of word N+1, and no bit is lost.
- No backpressure: the consumer must take om_data while om_valid is high. A later completion overwrites om_data.
- om_abort never coincides with om_valid.

## Configuration
- SPI_RX_PARITY_EN:
  - Defined: NBITS = DATA_W+1; the om_parity_err port exists; PARITY_ODD is honoured.
  - Undefined: NBITS = DATA_W; no parity logic and no om_parity_err port; PARITY_ODD is ignored.

## Structure
- Shared package spi_pkg holds:
  - bit-order constants SPI_LSB_FIRST=0 and SPI_MSB_FIRST=1;
  - a counter-width function clog2-based on NBITS;
  - the PARITY_EVEN/PARITY_ODD constants.
- No sub-module: counter, shifter and flags form one flat block.

## Test plan
- LSB-first, DATA_W=8: bits 1,0,1,0,0,1,0,1 → om_data=0xA5 and om_valid high for exactly 1 cycle, one cycle after the 8th pulse.
- MSB-first, DATA_W=8: bits 1,0,1,0,0,1,0,1 → om_data=0xA5. Next word LSB-first, bits 0,1,1,1,1,0,0,0 → om_data=0x1E.
- Abort: 3 pulses, then im_work_en low → om_abort one cycle, om_busy 1→0, om_data unchanged. A following full word 0x3C is received correctly. Pulses with im_work_en low produce no state change.
- DATA_W=16, pulses every cycle for words 0xBEEF then 0x1234 (MSB-first) → two om_valid pulses exactly 16 cycles apart with the correct values.
- SPI_RX_PARITY_EN, PARITY_ODD=0:
  - 0xA5 with parity bit 0 → om_parity_err=0;
  - 0xA5 with parity bit 1 → om_parity_err=1.
  - Both cases: om_valid one cycle after the 9th pulse.
- rst_n asserted after 5 bits → all outputs 0 immediately and no om_abort. The next full word after release decodes correctly.
